// File: rtl/led_matrix_scan_pkg.sv
// ---------------------------------------------------------------------------
// led_matrix_scan_pkg
//   Shared types and constants for the LED matrix scan controller.
//   - MATRIX_ROWS     : rows per column (row pattern width)
//   - MATRIX_COLS_MAX : largest column count the 3-bit column index can address
//   - state_e         : scan FSM states
//   - row_pat_t       : one column's row pattern, 1 = LED on
// ---------------------------------------------------------------------------
package led_matrix_scan_pkg;

    localparam int MATRIX_ROWS     = 7;
    localparam int MATRIX_COLS_MAX = 8;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_LIT   = 1'b1
    } state_e;

    typedef logic [MATRIX_ROWS-1:0] row_pat_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_matrix_scan_frame_buffer_dp.sv
// ---------------------------------------------------------------------------
// frame_buffer_dp
//   Double frame buffer. The host writes the back buffer; the scanner reads
//   the front buffer. A swap strobe copies the whole back buffer to the front
//   buffer in one edge.
//   Ports:
//     clk, rst_n       : clock, async active-low reset (clears both buffers)
//     wr_en            : write back[wr_col] <= wr_data this edge
//     wr_col, wr_data  : write column index / row pattern
//     swap             : copy back -> front this edge
//     rd_col, rd_data  : combinational read of front[rd_col]
// ---------------------------------------------------------------------------
module frame_buffer_dp
    import led_matrix_scan_pkg::*;
#(
    parameter int NUM_COLS = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     wr_en,
    input  logic [2:0] wr_col,
    input  row_pat_t wr_data,
    input  logic     swap,
    input  logic [2:0] rd_col,
    output row_pat_t rd_data
);

    // Storage is sized to the full 3-bit address space so any index is legal;
    // entries at or above NUM_COLS are never written and stay dark.
    row_pat_t front_q [MATRIX_COLS_MAX];
    row_pat_t front_d [MATRIX_COLS_MAX];
    row_pat_t back_q  [MATRIX_COLS_MAX];
    row_pat_t back_d  [MATRIX_COLS_MAX];

    always_comb begin
        front_d = front_q;
        back_d  = back_q;
        // Out-of-range columns are accepted by the handshake but dropped here.
        if (wr_en && (int'(wr_col) < NUM_COLS)) begin
            back_d[wr_col] = wr_data;
        end
        if (swap) begin
            front_d = back_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MATRIX_COLS_MAX; i++) begin
                front_q[i] <= '0;
                back_q[i]  <= '0;
            end
        end else begin
            front_q <= front_d;
            back_q  <= back_d;
        end
    end

    assign rd_data = front_q[rd_col];

endmodule

// File: rtl/led_matrix_scan.sv
// ---------------------------------------------------------------------------
// led_matrix_scan
//   Time-multiplexed scan controller for a column-scanned LED matrix.
//   Each column gets BLANK dark cycles followed by DWELL lit cycles. A host
//   loads the back buffer through a valid/ready port and requests a swap; the
//   swap lands only on the frame wrap so a partial frame is never shown.
//   Ports:
//     clk, rst_n   : clock, async active-low reset
//     load_valid   : host offers a column write
//     load_ready   : back buffer accepts writes (low while a swap is pending)
//     load_col     : column index of the write (>= NUM_COLS is dropped)
//     load_data    : row pattern, 1 = LED on
//     swap_req     : one-cycle pulse requesting a back -> front copy
//     col_sel      : column index to the column decoder
//     col_en       : high while the current column is lit
//     row_n        : active-low row drive
//     frame_done   : one-cycle pulse after each frame wrap
// ---------------------------------------------------------------------------
module led_matrix_scan
    import led_matrix_scan_pkg::*;
#(
    parameter int NUM_COLS = 5,
    parameter int DWELL    = 50000,
    parameter int BLANK    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [2:0]             load_col,
    input  logic [MATRIX_ROWS-1:0] load_data,
    input  logic                   swap_req,
    output logic [2:0]             col_sel,
    output logic                   col_en,
    output logic [MATRIX_ROWS-1:0] row_n,
    output logic                   frame_done
);

    localparam int CNT_MAX = max_int(DWELL, BLANK);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [2:0]       LAST_COL   = 3'(NUM_COLS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       col_q, col_d;
    logic             col_en_q, col_en_d;
    row_pat_t         row_n_q, row_n_d;
    logic             frame_done_q, frame_done_d;
    logic             swap_pending_q, swap_pending_d;

    logic             wrap;
    logic             do_swap;
    logic             wr_en;
    row_pat_t         front_rd;

    assign load_ready = !swap_pending_q;
    assign wr_en      = load_valid && load_ready;
    // A swap request is only ever honoured at a wrap after it was registered,
    // so the copy uses the pending flag, not the live request.
    assign do_swap    = wrap && swap_pending_q;

    frame_buffer_dp #(
        .NUM_COLS (NUM_COLS)
    ) u_fb (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_col  (load_col),
        .wr_data (load_data),
        .swap    (do_swap),
        .rd_col  (col_d),
        .rd_data (front_rd)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        col_d   = col_q;
        wrap    = 1'b0;

        unique case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_LIT;
                    cnt_d   = '0;
                end
            end
            ST_LIT: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase

        frame_done_d = wrap;

        // Pending is sticky until the wrap that performs the copy; a request
        // landing on a wrap edge with nothing pending arms the next wrap.
        if (swap_pending_q) begin
            swap_pending_d = !wrap;
        end else begin
            swap_pending_d = swap_req;
        end

        // Row drive is computed from the next state so col_en and row_n move
        // together. The front buffer only changes on a wrap, which always
        // enters BLANK, so the pattern read on entry to LIT is stable.
        col_en_d = (state_d == ST_LIT);
        row_n_d  = col_en_d ? ~front_rd : '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_BLANK;
            cnt_q          <= '0;
            col_q          <= '0;
            col_en_q       <= 1'b0;
            row_n_q        <= '1;
            frame_done_q   <= 1'b0;
            swap_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            col_q          <= col_d;
            col_en_q       <= col_en_d;
            row_n_q        <= row_n_d;
            frame_done_q   <= frame_done_d;
            swap_pending_q <= swap_pending_d;
        end
    end

    assign col_sel    = col_q;
    assign col_en     = col_en_q;
    assign row_n      = row_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/led_matrix_scan.md
# led_matrix_scan

Time-multiplexed scan controller for the 5-column x 7-row LED matrix. It holds a double-buffered frame, steps through the columns at a fixed dwell rate, and drives `col_sel` into the column decoder along with the active-low row pattern for the current column. A host loads the back buffer column by column through a valid/ready port and requests a buffer swap. The swap takes effect only at a frame boundary, so a partial frame is never displayed.

## Interface
- `NUM_COLS`, 5: columns scanned, 1..8.
- `DWELL`, 50000: clock cycles each column is lit, >= 1.
- `BLANK`, 2: blank cycles before each column is lit (anti-ghosting), >= 1.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `load_valid`, in, 1: host offers one column write.
- `load_ready`, out, 1: back buffer accepts a write.
- `load_col`, in, 3: column index of the write.
- `load_data`, in, 7: row pattern for that column; 1 = LED on.
- `swap_req`, in, 1: single-cycle pulse requesting a back-to-front copy.
- `col_sel`, out, 3: column index sent to the column decoder.
- `col_en`, out, 1: high while the current column is lit.
- `row_n`, out, 7: active-low row drive.
- `frame_done`, out, 1: one-cycle pulse at each frame wrap.

## Operation
- Storage: front and back buffers, each NUM_COLS x 7 bits. Reset clears both to 0 (dark).
- FSM states and transitions:
  - BLANK: `col_en`=0, `row_n`=7'h7F. After BLANK cycles, go to LIT.
  - LIT: `col_en`=1, `row_n`=~front[`col_sel`]. After DWELL cycles, go to BLANK and advance the column.
- Column advance:
  - `col_sel` increments mod NUM_COLS.
  - On wrap from NUM_COLS-1 to 0, `frame_done` pulses on that same edge.
  - On that same edge, if `swap_pending`=1, front <= back and `swap_pending` clears.
- Load handshake:
  - A write occurs on a clock edge where `load_valid` && `load_ready`; back[`load_col`] <= `load_data`.
  - `load_col` >= NUM_COLS: the write is accepted and discarded.
  - `load_ready` = !`swap_pending`, so the back buffer is frozen until it has been copied.
- Swap request:
  - `swap_req` sets `swap_pending`.
  - `swap_req` while already pending has no effect.
  - `swap_req` on the same edge as a wrap is not applied at that wrap. It sets pending and applies at the next wrap.
- Reset, including mid-frame:
  - `col_sel`=0, FSM=BLANK, dwell counter=0, `swap_pending`=0.
  - `col_en`=0, `row_n`=7'h7F, `frame_done`=0, `load_ready`=1.
  - Buffers cleared.

## Timing
- All outputs are registered. `row_n` and `col_en` change on the same edge as the state change. There is no cycle where `col_en`=1 with a stale `row_n`.
- Column period = BLANK + DWELL cycles. Frame period = NUM_COLS x (BLANK + DWELL).
- First lit cycle after reset release: `col_en`=1 on edge BLANK, with column 0.
- Write-to-display latency:
  - Front buffer updates at the first wrap edge after `swap_req` is registered.
  - Worst case is one full frame period plus 1 cycle.
- `load_ready` falls on the edge after `swap_req`. It rises on the wrap edge that performs the copy.
- The dwell counter is $clog2(max(DWELL, BLANK)) bits wide. It reloads to 0 on each state change and never wraps mid-state.

## Structure
- Shared package holds:
  - `MATRIX_ROWS`=7 and `MATRIX_COLS_MAX`=8.
  - State enum {ST_BLANK, ST_LIT}.
  - Row-pattern typedef (7 bits).
- One natural sub-module: `frame_buffer_dp`. It is the double buffer with a write port, a read port and a swap strobe.
- The FSM and counter stay in the top level.
- `col_sel` connects directly to the existing column decoder.

## Test plan
Benches use DWELL=4, BLANK=1, NUM_COLS=5.
- Reset release:
  - Stimulus: no loads or swaps.
  - Response: `col_sel` steps 0,1,2,3,4,0 every 5 cycles with `row_n`=7'h7F throughout.
  - Response: `frame_done` pulses every 25 cycles.
- Load and swap:
  - Stimulus: load columns 0..4 with 7'h01, 7'h02, 7'h04, 7'h08, 7'h10, then pulse `swap_req`.
  - Response: after the next wrap, column k lit shows `row_n`=~(1<<k).
  - Response: `load_ready` is 0 from the swap until that wrap.
- Swap coincident with wrap:
  - Stimulus: `swap_req` on the wrap edge.
  - Response: front is unchanged for that frame and updates at the following wrap.
- Write while pending:
  - Stimulus: hold `load_valid` during `swap_pending`.
  - Response: no write occurs; the write completes on the cycle after `load_ready` rises.
- Out-of-range column:
  - Stimulus: `load_col`=6.
  - Response: the write is accepted, and back-buffer columns 0..4 are unchanged after the swap.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 during LIT of column 3.
  - Response: outputs immediately go to `col_en`=0, `row_n`=7'h7F, `col_sel`=0.
  - Response: the display is dark after release until a new swap.
